// File: rtl/pcie_tx_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pcie_tx_arbiter_pkg: FSM encodings and default sizing for the TX arbiter
// Rev 1.0
// ------------------------------------------------------------------
package pcie_tx_arbiter_pkg;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_XFER = 2'd2;

    localparam int c_DEF_DW        = 16;
    localparam int c_DEF_TIMEOUT   = 1024;
    localparam int c_DEF_MAX_BEATS = 256;

endpackage
`default_nettype wire

// File: rtl/pcie_tx_arbiter_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// pcie_tx_arbiter_rr_pick: combinational round-robin pick, first request after ptr
// Rev 1.0
// ------------------------------------------------------------------
module pcie_tx_arbiter_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic                    valid_o,
    output logic [$clog2(NREQ)-1:0] idx_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] w_j;

    // Walk from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        w_j     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_j = IW'((int'(ptr_i) + k) % NREQ);
            if (req_i[w_j]) begin
                idx_o = w_j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcie_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// pcie_tx_arbiter: shares the PCIe x1 TX TLP port among NREQ requesters
// Rev 1.0
// ------------------------------------------------------------------
module pcie_tx_arbiter
    import pcie_tx_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = c_DEF_DW,
    parameter int TIMEOUT   = c_DEF_TIMEOUT,
    parameter int MAX_BEATS = c_DEF_MAX_BEATS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         last_i,
    input  logic [NREQ*DW-1:0]      data_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    tx_req_vc0_o,
    input  logic                    tx_rdy_vc0_i,
    output logic                    tx_st_vc0_o,
    output logic                    tx_end_vc0_o,
    output logic                    tx_nlfy_vc0_o,
    output logic [DW-1:0]           tx_data_vc0_o,
    output logic                    busy_o,
    output logic [$clog2(NREQ)-1:0] cur_id_o,
    output logic                    err_timeout_o,
    output logic                    err_overrun_o,
    output logic [$clog2(NREQ)-1:0] err_id_o
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(MAX_BEATS);
    localparam logic [TW-1:0] c_WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] c_BEAT_LAST = BW'(MAX_BEATS - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] sel_q, ptr_q, err_id_q;
    logic [TW-1:0] wait_q;
    logic [BW-1:0] beat_q;
    logic          err_timeout_q, err_overrun_q;

    logic          w_pick_valid;
    logic [IW-1:0] w_pick_idx;
    logic          w_req_sel, w_last_sel, w_beat, w_end, w_overrun, w_timeout;

    pcie_tx_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    always_comb begin
        w_req_sel  = req_i[sel_q];
        w_last_sel = last_i[sel_q];
        w_beat     = (state_q == c_XFER) && tx_rdy_vc0_i;
        w_overrun  = w_beat && (beat_q == c_BEAT_LAST) && !w_last_sel;
        w_end      = w_beat && (w_last_sel || (beat_q == c_BEAT_LAST));
        // tx_rdy outranks both a dropped request and an expiring wait.
        w_timeout  = (state_q == c_REQ) && !tx_rdy_vc0_i && w_req_sel && (wait_q == c_WAIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (w_pick_valid) state_d = c_REQ;
            c_REQ: begin
                if (tx_rdy_vc0_i)               state_d = c_XFER;
                else if (!w_req_sel || w_timeout) state_d = c_IDLE;
            end
            c_XFER: if (w_end) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q         <= '0;
            ptr_q         <= IW'(NREQ - 1);
            wait_q        <= '0;
            beat_q        <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_id_q      <= '0;
        end else begin
            err_timeout_q <= w_timeout;
            err_overrun_q <= w_overrun;
            if (w_timeout || w_overrun) begin
                err_id_q <= sel_q;
            end
            if ((state_q == c_IDLE) && w_pick_valid) begin
                sel_q  <= w_pick_idx;
                wait_q <= '0;
                beat_q <= '0;
            end
            if ((state_q == c_REQ) && !tx_rdy_vc0_i) begin
                wait_q <= wait_q + 1'b1;
            end
            if (w_beat) begin
                beat_q <= beat_q + 1'b1;
            end
            if (w_end || w_timeout) begin
                ptr_q <= sel_q;
            end
        end
    end

    always_comb begin
        tx_req_vc0_o  = (state_q != c_IDLE);
        busy_o        = (state_q != c_IDLE);
        tx_st_vc0_o   = w_beat && (beat_q == '0);
        tx_end_vc0_o  = w_end;
        tx_nlfy_vc0_o = w_overrun;
        gnt_o         = '0;
        if (w_beat) begin
            gnt_o[sel_q] = 1'b1;
        end
        tx_data_vc0_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_q == c_XFER) && (sel_q == IW'(i))) begin
                tx_data_vc0_o = data_i[i*DW +: DW];
            end
        end
        cur_id_o      = sel_q;
        err_timeout_o = err_timeout_q;
        err_overrun_o = err_overrun_q;
        err_id_o      = err_id_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pcie_tx_arbiter: scoreboard bench for the PCIe TX arbiter (TIMEOUT=16, MAX_BEATS=8)
// Rev 1.0
// ------------------------------------------------------------------
module tb_pcie_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, last, gnt;
    logic [NREQ*DW-1:0] data;
    logic              tx_req, rdy, tx_st, tx_end, tx_nlfy, busy, err_to, err_ov;
    logic [DW-1:0]     tx_data;
    logic [1:0]        cur_id, err_id;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic          st;
        logic          en;
        logic          nl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   active[NREQ], len[NREQ], beat[NREQ], pkt[NREQ], left[NREQ], gcnt[NREQ];
    logic [NREQ-1:0] last_g;
    logic            last_end;

    pcie_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(16), .MAX_BEATS(8)) dut (
        .clk(clk), .rst(rst), .req_i(req), .last_i(last), .data_i(data), .gnt_o(gnt),
        .tx_req_vc0_o(tx_req), .tx_rdy_vc0_i(rdy), .tx_st_vc0_o(tx_st), .tx_end_vc0_o(tx_end),
        .tx_nlfy_vc0_o(tx_nlfy), .tx_data_vc0_o(tx_data), .busy_o(busy), .cur_id_o(cur_id),
        .err_timeout_o(err_to), .err_overrun_o(err_ov), .err_id_o(err_id)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdata(int id, int p, int b);
        logic [DW-1:0] d;
        d = {4'hA, 4'(id), 4'(p), 4'(b)};
        return d;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]  = (active[i] != 0);
            last[i] = (active[i] != 0) && (len[i] != 0) && (beat[i] == len[i] - 1);
            data[i*DW +: DW] = mkdata(i, pkt[i], beat[i]);
        end
    endtask

    task automatic start(int id, int ln, int n);
        active[id] = 1; len[id] = ln; left[id] = n; beat[id] = 0;
        drive();
    endtask

    task automatic push_beat(int id, int p, int b, logic st, logic en, logic nl);
        exp_t x;
        x.id = 2'(id); x.data = mkdata(id, p, b); x.st = st; x.en = en; x.nl = nl;
        exp_q.push_back(x);
    endtask

    task automatic push_pkt(int id, int p, int n, logic ovr);
        for (int b = 0; b < n; b++) push_beat(id, p, b, b == 0, b == n - 1, ovr && (b == n - 1));
    endtask

    // One clock: score any beat seen at the falling edge, then advance the requester model.
    task automatic tick();
        exp_t x;
        logic [NREQ-1:0] g, eg;
        logic e;
        @(negedge clk);
        g = gnt; e = tx_end;
        last_g = g; last_end = e;
        if (g != '0 || tx_st || tx_end || tx_nlfy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got gnt=%b data=%h st=%b end=%b, required no beat", g, tx_data, tx_st, tx_end);
            end else begin
                x = exp_q.pop_front();
                eg = '0; eg[x.id] = 1'b1;
                if ({g, tx_data, tx_st, tx_end, tx_nlfy} !== {eg, x.data, x.st, x.en, x.nl}) begin
                    errors++;
                    $display("FAIL beat: got gnt=%b data=%h st=%b end=%b nlfy=%b, required gnt=%b data=%h st=%b end=%b nlfy=%b",
                             g, tx_data, tx_st, tx_end, tx_nlfy, eg, x.data, x.st, x.en, x.nl);
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                gcnt[i]++;
                if (e) begin
                    pkt[i]++; beat[i] = 0; left[i]--; active[i] = (left[i] > 0) ? 1 : 0;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            active[i] = 0; len[i] = 0; beat[i] = 0; pkt[i] = 0; left[i] = 0; gcnt[i] = 0;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b0;
        exp_q.delete();
        clear_model();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(int budget, string name);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            tick(); #1;
            if (exp_q.size() == 0 && busy === 1'b0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats pending busy=%b, required 0 pending and idle", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0;
        exp_q.delete();
        clear_model();
        start(0, 1, 1);
        tick(); tick(); #1;
        checks++;
        if ({tx_req, busy, gnt, tx_st, tx_end, tx_nlfy, tx_data} !== '0) begin
            errors++;
            $display("FAIL reset_tx: got req=%b busy=%b gnt=%b data=%h, required all 0", tx_req, busy, gnt, tx_data);
        end
        checks++;
        if ({err_to, err_ov, err_id, cur_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_err: got to=%b ov=%b err_id=%0d cur_id=%0d, required 0", err_to, err_ov, err_id, cur_id);
        end
        push_pkt(0, 0, 1, 1'b0);
        rst = 1'b0;
        tick(); #1;
        checks++;
        if (busy !== 1'b1 || cur_id !== 2'd0 || tx_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_pick: got busy=%b cur_id=%0d req=%b, required 1 0 1", busy, cur_id, tx_req);
        end
        rdy = 1'b1;
        run_until_idle(10, "reset");
    endtask

    task automatic test_single();
        do_reset();
        start(0, 4, 1);
        push_pkt(0, 0, 4, 1'b0);
        tick(); #1;
        checks++;
        if (tx_req !== 1'b1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL single_req: got tx_req=%b gnt=%b, required 1 0000", tx_req, gnt);
        end
        tick(); tick();
        rdy = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        #1;
        checks++;
        if (busy !== 1'b0 || tx_req !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_drop: got busy=%b tx_req=%b, required 0 0", busy, tx_req);
        end
        checks++;
        if (gcnt[0] != 4 || gcnt[1] + gcnt[2] + gcnt[3] != 0) begin
            errors++;
            $display("FAIL single_gnt_count: got %0d/%0d, required 4/0", gcnt[0], gcnt[1] + gcnt[2] + gcnt[3]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_pending: got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int ends;
        bit done;
        do_reset();
        rdy = 1'b1;
        start(0, 1, 2); start(1, 1, 1); start(2, 1, 1); start(3, 1, 1);
        push_pkt(0, 0, 1, 1'b0); push_pkt(1, 0, 1, 1'b0); push_pkt(2, 0, 1, 1'b0);
        push_pkt(3, 0, 1, 1'b0); push_pkt(0, 1, 1, 1'b0);
        ends = 0; done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick(); #1;
            if (last_end) begin
                ends++;
                checks++;
                if (tx_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_gap: got tx_req=%b after end beat, required 0", tx_req);
                end
            end
            if (exp_q.size() == 0 && busy === 1'b0) done = 1;
        end
        checks++;
        if (!done || ends != 5) begin
            errors++;
            $display("FAIL rr_tlps: got %0d ends pending=%0d, required 5 ends 0 pending", ends, exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic [NREQ-1:0] eg;
        do_reset();
        start(0, 3, 1);
        push_pkt(0, 0, 3, 1'b0);
        tick();
        rdy = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            rdy = (k % 2 == 0);
            tick();
            eg = {3'b000, rdy};
            checks++;
            if (last_g !== eg) begin
                errors++;
                $display("FAIL stall_gnt_mirror: got %b at step %0d, required %b", last_g, k, eg);
            end
        end
        rdy = 1'b0;
        #1;
        checks++;
        if (gcnt[0] != 3 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_total: got gnt=%0d busy=%b pending=%0d, required 3 0 0", gcnt[0], busy, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start(1, 1, 1); start(2, 1, 1);
        push_pkt(2, 0, 1, 1'b0);
        tick();
        for (int k = 0; k < 15; k++) tick();
        #1;
        checks++;
        if (err_to !== 1'b0 || busy !== 1'b1 || cur_id !== 2'd1) begin
            errors++;
            $display("FAIL timeout_early: got err=%b busy=%b cur_id=%0d, required 0 1 1", err_to, busy, cur_id);
        end
        tick(); #1;
        checks++;
        if (err_to !== 1'b1 || err_id !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b err_id=%0d busy=%b, required 1 1 0", err_to, err_id, busy);
        end
        active[1] = 0; drive();
        tick(); #1;
        checks++;
        if (err_to !== 1'b0 || busy !== 1'b1 || cur_id !== 2'd2 || err_id !== 2'd1) begin
            errors++;
            $display("FAIL timeout_next: got err=%b busy=%b cur_id=%0d err_id=%0d, required 0 1 2 1", err_to, busy, cur_id, err_id);
        end
        rdy = 1'b1;
        run_until_idle(10, "timeout");
    endtask

    task automatic test_overrun();
        do_reset();
        rdy = 1'b1;
        start(2, 0, 1);
        push_pkt(2, 0, 8, 1'b1);
        tick(); tick();
        for (int k = 0; k < 7; k++) tick();
        #1;
        checks++;
        if (err_ov !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_early: got err=%b busy=%b, required 0 1", err_ov, busy);
        end
        tick(); #1;
        checks++;
        if (err_ov !== 1'b1 || err_id !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pulse: got err=%b err_id=%0d busy=%b, required 1 2 0", err_ov, err_id, busy);
        end
        tick(); #1;
        checks++;
        if (err_ov !== 1'b0 || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_after: got err=%b pending=%0d busy=%b, required 0 0 0", err_ov, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        rdy = 1'b1;
        start(0, 6, 1);
        for (int b = 0; b < 3; b++) push_beat(0, 0, b, b == 0, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick(); #1;
        checks++;
        if ({tx_req, busy, gnt, tx_st, tx_end, tx_nlfy, tx_data, err_to, err_ov} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got req=%b busy=%b gnt=%b end=%b data=%h, required all 0", tx_req, busy, gnt, tx_end, tx_data);
        end
        rst = 1'b0;
        clear_model();
        start(3, 1, 1); start(0, 1, 1);
        push_pkt(0, 0, 1, 1'b0); push_pkt(3, 0, 1, 1'b0);
        run_until_idle(20, "midreset");
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; req = '0; last = '0; data = '0;
        last_g = '0; last_end = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_timeout();
        test_overrun();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
